// File: rtl/player_missile.sv
// player_missile: a single player missile fired upward at the alien formation.
// The missile climbs MISSILE_STEP rows per tick. After each step the grid is
// scanned one alien per clock, in index order, for a hit. This block owns the
// alive mask and flags when every alien is dead.
// Optional scoring is enabled by defining PLAYER_MISSILE_SCORE_EN.
module player_missile #(
    parameter int ALIEN_ROWS   = 3,
    parameter int ALIEN_COLS   = 6,
    parameter int COL_PITCH    = 65,
    parameter int ROW_PITCH    = 40,
    parameter int ALIEN_W      = 50,
    parameter int ALIEN_H      = 30,
    parameter int SHIP_ROW     = 440,
    parameter int SHIP_HALF    = 15,
    parameter int MISSILE_STEP = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_tick,
    input  logic                             i_fire,
    input  logic [9:0]                       i_ship_col,
    input  logic [8:0]                       i_aliens_row,
    input  logic [9:0]                       i_aliens_col,
    output logic [8:0]                       o_missile_row,
    output logic [9:0]                       o_missile_col,
    output logic                             o_missile_active,
    output logic [ALIEN_ROWS*ALIEN_COLS-1:0] o_alien_alive,
    output logic                             o_hit_pulse,
    output logic [4:0]                       o_hit_index,
    output logic                             o_all_dead,
    output logic [15:0]                      o_score
);

    localparam int N  = ALIEN_ROWS * ALIEN_COLS;
    localparam int RW = (ALIEN_ROWS > 1) ? $clog2(ALIEN_ROWS) : 1;
    localparam int CW = (ALIEN_COLS > 1) ? $clog2(ALIEN_COLS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

    logic [1:0]    r_state;
    logic [8:0]    r_missile_row;
    logic [9:0]    r_missile_col;
    logic          r_active;
    logic [N-1:0]  r_alive;
    logic          r_hit_pulse;
    logic [4:0]    r_hit_index;
    logic          r_all_dead;
    logic          r_pend;
    logic [4:0]    r_scan_idx;
    logic [RW-1:0] r_scan_r;
    logic [CW-1:0] r_scan_c;

    // Hitbox bounds of the alien under scan, at 11 bits so nothing wraps
    logic [10:0] w_col_lo;
    logic [10:0] w_col_hi;
    logic [10:0] w_row_lo;
    logic [10:0] w_row_hi;
    logic [10:0] w_mcol;
    logic [10:0] w_mrow;
    logic        w_in_box;
    logic        w_hit;
    logic        w_last;

    assign w_col_lo = {1'b0, i_aliens_col} + 11'(r_scan_c) * 11'(COL_PITCH);
    assign w_col_hi = w_col_lo + 11'(ALIEN_W);
    assign w_row_lo = {2'b00, i_aliens_row} + 11'(r_scan_r) * 11'(ROW_PITCH);
    assign w_row_hi = w_row_lo + 11'(ALIEN_H);
    assign w_mcol   = {1'b0, r_missile_col};
    assign w_mrow   = {2'b00, r_missile_row};
    assign w_in_box = (w_mcol >= w_col_lo) && (w_mcol < w_col_hi) &&
                      (w_mrow >= w_row_lo) && (w_mrow < w_row_hi);
    assign w_hit    = r_alive[r_scan_idx] && w_in_box;
    assign w_last   = (r_scan_idx == 5'(N - 1));

    // Missile flight, grid scan and kill bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_missile_row <= '0;
            r_missile_col <= '0;
            r_active      <= 1'b0;
            r_alive       <= '1;
            r_hit_pulse   <= 1'b0;
            r_hit_index   <= '0;
            r_pend        <= 1'b0;
            r_scan_idx    <= '0;
            r_scan_r      <= '0;
            r_scan_c      <= '0;
        end else begin
            r_hit_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pend <= 1'b0;
                    if (i_fire && !r_all_dead) begin
                        r_missile_row <= 9'(SHIP_ROW);
                        r_missile_col <= i_ship_col + 10'(SHIP_HALF);
                        r_active      <= 1'b1;
                        r_state       <= S_FLY;
                    end
                end
                S_FLY: begin
                    if (i_tick || r_pend) begin
                        r_pend <= 1'b0;
                        if (r_missile_row < 9'(MISSILE_STEP)) begin
                            // Left the top of the screen: a miss
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_missile_row <= r_missile_row - 9'(MISSILE_STEP);
                            r_scan_idx    <= '0;
                            r_scan_r      <= '0;
                            r_scan_c      <= '0;
                            r_state       <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    // One-deep tick memory; extra ticks in the same scan are lost
                    if (i_tick) begin
                        r_pend <= 1'b1;
                    end
                    if (w_hit) begin
                        r_alive[r_scan_idx] <= 1'b0;
                        r_hit_index         <= r_scan_idx;
                        r_hit_pulse         <= 1'b1;
                        r_active            <= 1'b0;
                        r_pend              <= 1'b0;
                        r_state             <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_FLY;
                    end else begin
                        r_scan_idx <= r_scan_idx + 5'd1;
                        if (r_scan_c == CW'(ALIEN_COLS - 1)) begin
                            r_scan_c <= '0;
                            r_scan_r <= r_scan_r + RW'(1);
                        end else begin
                            r_scan_c <= r_scan_c + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All-dead flag trails the alive mask by one clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_all_dead <= 1'b0;
        end else begin
            r_all_dead <= ~|r_alive;
        end
    end

`ifdef PLAYER_MISSILE_SCORE_EN
    logic [15:0] r_score;
    logic [15:0] w_score_inc;

    // Top row is worth the most: 10 points per row counted up from the bottom
    assign w_score_inc = 16'(10 * (ALIEN_ROWS - int'(r_scan_r)));

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Score accumulates on the kill cycle, saturating at full scale
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_score <= '0;
        end else if (r_state == S_SCAN && w_hit) begin
            r_score <= sat_add16(r_score, w_score_inc);
        end
    end

    assign o_score = r_score;
`else
    assign o_score = 16'd0;
`endif

    assign o_missile_row    = r_missile_row;
    assign o_missile_col    = r_missile_col;
    assign o_missile_active = r_active;
    assign o_alien_alive    = r_alive;
    assign o_hit_pulse      = r_hit_pulse;
    assign o_hit_index      = r_hit_index;
    assign o_all_dead       = r_all_dead;

endmodule

// File: tb/tb_player_missile.sv
// tb_player_missile: directed bench for player_missile with hand-computed
// expectations. Score checks follow PLAYER_MISSILE_SCORE_EN.
module tb_player_missile;

    localparam logic [17:0] ALL_ALIVE = 18'h3FFFF;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        fire;
    logic [9:0]  ship_col;
    logic [8:0]  aliens_row;
    logic [9:0]  aliens_col;
    logic [8:0]  missile_row;
    logic [9:0]  missile_col;
    logic        missile_active;
    logic [17:0] alien_alive;
    logic        hit_pulse;
    logic [4:0]  hit_index;
    logic        all_dead;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    int hit_count = 0;
    logic prev_pulse = 1'b0;
    logic ad_at_pulse = 1'b1;
    logic ad_after_pulse = 1'b0;

    player_missile dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tick           (tick),
        .i_fire           (fire),
        .i_ship_col       (ship_col),
        .i_aliens_row     (aliens_row),
        .i_aliens_col     (aliens_col),
        .o_missile_row    (missile_row),
        .o_missile_col    (missile_col),
        .o_missile_active (missile_active),
        .o_alien_alive    (alien_alive),
        .o_hit_pulse      (hit_pulse),
        .o_hit_index      (hit_index),
        .o_all_dead       (all_dead),
        .o_score          (score)
    );

    always #5 clk = ~clk;

    // Count kill pulses and capture AllDead at and just after each pulse
    always @(negedge clk) begin
        if (prev_pulse) ad_after_pulse = all_dead;
        if (hit_pulse) begin
            hit_count++;
            ad_at_pulse = all_dead;
        end
        prev_pulse = hit_pulse;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        @(posedge clk); #1;
        fire = 1'b0;
    endtask

    task automatic tick_raw();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    // One tick followed by enough idle clocks for a full scan
    task automatic do_tick();
        tick_raw();
        repeat (23) @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int max_ticks);
        for (int n = 0; n < max_ticks && missile_active; n++) do_tick();
        check("shot_end", {31'd0, missile_active}, 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; tick = 1'b0; fire = 1'b0;
        ship_col = 10'd0; aliens_row = 9'd0; aliens_col = 10'd10;
        #2 rst = 1'b1;
        #1;
        check("rst_alive", {14'd0, alien_alive}, {14'd0, ALL_ALIVE});
        check("rst_row", {23'd0, missile_row}, 32'd0);
        check("rst_col", {22'd0, missile_col}, 32'd0);
        check("rst_active", {31'd0, missile_active}, 32'd0);
        check("rst_pulse", {31'd0, hit_pulse}, 32'd0);
        check("rst_index", {27'd0, hit_index}, 32'd0);
        check("rst_alldead", {31'd0, all_dead}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Bottom-row kill
        ship_col = 10'd20;
        fire_pulse();
        check("launch_row", {23'd0, missile_row}, 32'd440);
        check("launch_col", {22'd0, missile_col}, 32'd35);
        check("launch_active", {31'd0, missile_active}, 32'd1);
        repeat (42) do_tick();
        check("k1_row", {23'd0, missile_row}, 32'd104);
        check("k1_hits", hit_count, 32'd1);
        check("k1_index", {27'd0, hit_index}, 32'd12);
        check("k1_alive", {14'd0, alien_alive}, {14'd0, ALL_ALIVE & ~(18'd1 << 12)});
        check("k1_active", {31'd0, missile_active}, 32'd0);

        // Second kill in the same column skips the dead alien
        fire_pulse();
        repeat (47) do_tick();
        check("k2_row", {23'd0, missile_row}, 32'd64);
        check("k2_hits", hit_count, 32'd2);
        check("k2_index", {27'd0, hit_index}, 32'd6);
        check("k2_alive", {14'd0, alien_alive},
              {14'd0, ALL_ALIVE & ~(18'd1 << 12) & ~(18'd1 << 6)});
`ifdef PLAYER_MISSILE_SCORE_EN
        check("k2_score", {16'd0, score}, 32'd30);
`else
        check("k2_score", {16'd0, score}, 32'd0);
`endif

        // Miss through the column gap, with a fire attempt while flying
        ship_col = 10'd50;
        fire_pulse();
        check("miss_col", {22'd0, missile_col}, 32'd65);
        repeat (10) do_tick();
        ship_col = 10'd100;
        fire = 1'b1;
        repeat (30) @(posedge clk);
        #1 fire = 1'b0;
        check("refire_col", {22'd0, missile_col}, 32'd65);
        check("refire_row", {23'd0, missile_row}, 32'd360);
        check("refire_active", {31'd0, missile_active}, 32'd1);
        repeat (45) do_tick();
        check("miss_row0", {23'd0, missile_row}, 32'd0);
        check("miss_active55", {31'd0, missile_active}, 32'd1);
        do_tick();
        check("miss_active56", {31'd0, missile_active}, 32'd0);
        check("miss_hits", hit_count, 32'd2);

        // Ticks during a scan: one is remembered, a third is dropped
        ship_col = 10'd20;
        fire_pulse();
        tick_raw();
        repeat (2) @(posedge clk);
        #1;
        tick_raw();
        repeat (2) @(posedge clk);
        #1;
        tick_raw();
        repeat (60) @(posedge clk);
        #1;
        check("pend_row", {23'd0, missile_row}, 32'd424);
        check("pend_active", {31'd0, missile_active}, 32'd1);
        run_until_idle(80);
        check("k3_index", {27'd0, hit_index}, 32'd0);
        check("k3_hits", hit_count, 32'd3);

        // Clear the remaining columns, bottom row first in each
        for (int c = 1; c < 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                ship_col = 10'(5 + 65 * c);
                fire_pulse();
                run_until_idle(70);
                check("clear_index", {27'd0, hit_index}, 32'((2 - k) * 6 + c));
            end
        end
        check("all_hits", hit_count, 32'd18);
        check("all_alive", {14'd0, alien_alive}, 32'd0);
        check("all_dead", {31'd0, all_dead}, 32'd1);
        check("ad_at_pulse", {31'd0, ad_at_pulse}, 32'd0);
        check("ad_after_pulse", {31'd0, ad_after_pulse}, 32'd1);
`ifdef PLAYER_MISSILE_SCORE_EN
        check("all_score", {16'd0, score}, 32'd360);
`else
        check("all_score", {16'd0, score}, 32'd0);
`endif
        fire_pulse();
        repeat (3) @(posedge clk);
        #1;
        check("dead_fire", {31'd0, missile_active}, 32'd0);

        // Reset restores the grid; a reset mid-scan aborts the missile
        rst = 1'b1;
        #1;
        check("rst2_alive", {14'd0, alien_alive}, {14'd0, ALL_ALIVE});
        check("rst2_alldead", {31'd0, all_dead}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ship_col = 10'd20;
        fire_pulse();
        repeat (5) do_tick();
        tick_raw();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst3_active", {31'd0, missile_active}, 32'd0);
        check("rst3_alive", {14'd0, alien_alive}, {14'd0, ALL_ALIVE});
        check("rst3_row", {23'd0, missile_row}, 32'd0);
        check("rst3_pulse", {31'd0, hit_pulse}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_missile.md
Name: player_missile

Overview:
- Player-side counterpart to the alien formation mover: fires a single missile upward from the player ship toward the descending formation.
- Consumes the formation's top-left position (AliensRow/AliensCol) and owns the alive mask of the alien grid.
- Resolves missile-vs-alien hits with a sequential scan after every missile step.
- Feeds the renderer (missile position, alive mask) and game control (hit pulse, all-dead).

Parameters:
- ALIEN_ROWS, 3, rows in the formation.
- ALIEN_COLS, 6, columns in the formation.
- COL_PITCH, 65, horizontal pixel pitch between alien origins.
- ROW_PITCH, 40, vertical pixel pitch between alien origins.
- ALIEN_W, 50, alien hitbox width in pixels.
- ALIEN_H, 30, alien hitbox height in pixels.
- SHIP_ROW, 440, missile launch row.
- SHIP_HALF, 15, offset from ShipCol to the missile column.
- MISSILE_STEP, 8, rows travelled per Tick.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Tick  in  1  one-cycle missile movement strobe
- Fire  in  1  level fire request
- ShipCol  in  10  ship left column
- AliensRow  in  9  formation top row
- AliensCol  in  10  formation left column
- MissileRow  out  9  missile row
- MissileCol  out  10  missile column
- MissileActive  out  1  missile in flight
- AlienAlive  out  ALIEN_ROWS*ALIEN_COLS  alive mask; bit i = row i/ALIEN_COLS, col i%ALIEN_COLS
- HitPulse  out  1  one-cycle pulse on kill
- HitIndex  out  5  index of the last killed alien
- AllDead  out  1  AlienAlive == 0, registered
- ScoreOut  out  16  score (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - State IDLE; AlienAlive all ones.
  - MissileRow=0, MissileCol=0, MissileActive=0, HitPulse=0, HitIndex=0, AllDead=0, ScoreOut=0, pending-tick flag cleared.
  - Reset mid-flight or mid-scan aborts with no hit recorded.
- IDLE:
  - Fire=1 and AllDead=0 → next edge: MissileRow=SHIP_ROW, MissileCol=ShipCol+SHIP_HALF (10-bit wrap), MissileActive=1, go FLY.
  - Fire ignored in every other state and while AllDead=1.
- FLY, on Tick or pending flag (flag cleared):
  - MissileRow < MISSILE_STEP → MissileActive=0, go IDLE (off-screen miss).
  - Otherwise MissileRow -= MISSILE_STEP, r=0, c=0, go SCAN.
- SCAN, one alien per clock in index order:
  - Hit condition: AlienAlive[idx] && MissileCol >= AliensCol+c*COL_PITCH && MissileCol < AliensCol+c*COL_PITCH+ALIEN_W && MissileRow >= AliensRow+r*ROW_PITCH && MissileRow < AliensRow+r*ROW_PITCH+ALIEN_H.
  - All bounds computed at 11 bits unsigned, with no wrap.
  - Hit → next edge: clear AlienAlive[idx], HitIndex=idx, HitPulse=1 for exactly one cycle, MissileActive=0, go IDLE. The first hit in index order wins; one kill per missile.
  - No hit at the last index → go FLY.
  - c wraps to 0 and r increments at c=ALIEN_COLS-1.
  - AliensRow/AliensCol are sampled live each SCAN cycle; a formation move mid-scan is permitted.
- Tick during SCAN sets the one-deep pending flag; further Ticks during the same scan are dropped.
- Scan length: ALIEN_ROWS*ALIEN_COLS cycles (18 by default).
- AllDead updates the cycle after the final alive bit clears.
- Missile outputs hold their last values in IDLE; only MissileActive qualifies them.

Optional Feature:
- Macro: PLAYER_MISSILE_SCORE_EN.
- With the macro: on each HitPulse, ScoreOut += 10*(ALIEN_ROWS - r), i.e. top row 30, middle 20, bottom 10. ScoreOut saturates at 16'hFFFF and clears only on Reset.
- Without the macro: ScoreOut is tied to 0 and no adder is built.

Test Plan:
- Bottom-row kill: AliensRow=0, AliensCol=10, ShipCol=20, Fire pulse, 42 Ticks → MissileRow=104, HitPulse once, HitIndex=12, AlienAlive bit 12 cleared, MissileActive=0.
- Second kill, same column: fire again, 47 Ticks → MissileRow=64, HitIndex=6 (the dead bit-12 alien is skipped); with PLAYER_MISSILE_SCORE_EN, ScoreOut=30.
- Miss between columns: ShipCol=50 (MissileCol=65, in the 60..74 gap), Fire → no HitPulse. Row reaches 0 at Tick 55; Tick 56 → MissileActive=0, state IDLE.
- Fire while flying: re-assert Fire at Tick 10 with ShipCol changed → MissileCol unchanged, no relaunch.
- Tick during SCAN: two Ticks 3 cycles apart → exactly two MISSILE_STEP decrements; a third Tick inside the same scan is dropped.
- Clear all 18 aliens → AllDead=1 the cycle after the last HitPulse; subsequent Fire ignored. Reset mid-flight → AlienAlive all ones, MissileActive=0 immediately.
